// File: rtl/ram_burst_arbiter.sv
// Two-requester round-robin arbiter that runs 1..16 beat read/write bursts
// against one port of a single-clock RAM with a registered (1-cycle) read.
module ram_burst_arbiter #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 6
) (
  input  logic          C,
  input  logic          nR,
  input  logic          r0REQ,
  input  logic          r1REQ,
  input  logic          r0WE,
  input  logic          r1WE,
  input  logic [AW-1:0] r0A,
  input  logic [AW-1:0] r1A,
  input  logic [3:0]    r0LEN,
  input  logic [3:0]    r1LEN,
  input  logic [DW-1:0] r0D,
  input  logic [DW-1:0] r1D,
  output logic          r0GNT,
  output logic          r1GNT,
  output logic          r0DACK,
  output logic          r1DACK,
  output logic          r0QV,
  output logic          r1QV,
  output logic [DW-1:0] Q,
  output logic          BUSY,
  output logic          mWR,
  output logic [AW-1:0] mA,
  output logic [DW-1:0] mD,
  input  logic [DW-1:0] mQ
);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    beat_q, beat_d;
  logic          last_q, last_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_own_q, rd_own_d;

  logic gnt_any, gnt_sel, own_req, beat_last;

  always_comb begin
    gnt_any   = r0REQ | r1REQ;
    // On a tie the requester not served last wins.
    gnt_sel   = (r0REQ & r1REQ) ? ~last_q : r1REQ;
    own_req   = owner_q ? r1REQ : r0REQ;
    beat_last = (beat_q == len_q);
  end

  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      last_q    <= 1'b1;
      rd_pend_q <= 1'b0;
      rd_own_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      last_q    <= last_d;
      rd_pend_q <= rd_pend_d;
      rd_own_q  <= rd_own_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_any) state_d = StBurst;
      StBurst: if (beat_last || !own_req) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    last_d    = last_q;
    rd_pend_d = 1'b0;
    rd_own_d  = rd_own_q;
    if (state_q == StIdle && gnt_any) begin
      owner_d = gnt_sel;
      we_d    = gnt_sel ? r1WE : r0WE;
      addr_d  = gnt_sel ? r1A : r0A;
      len_d   = gnt_sel ? r1LEN : r0LEN;
      beat_d  = '0;
      last_d  = gnt_sel;
    end
    if (state_q == StBurst) begin
      beat_d = beat_q + 4'd1;
      // Read data returns from the RAM one cycle after its beat.
      if (!we_q) begin
        rd_pend_d = 1'b1;
        rd_own_d  = owner_q;
      end
    end
  end

  always_comb begin
    r0GNT  = 1'b0;
    r1GNT  = 1'b0;
    r0DACK = 1'b0;
    r1DACK = 1'b0;
    BUSY   = 1'b0;
    mWR    = 1'b0;
    mA     = '0;
    mD     = owner_q ? r1D : r0D;
    if (state_q == StIdle) begin
      // Gated by nR so no grant shows while reset is held.
      r0GNT = nR & gnt_any & ~gnt_sel;
      r1GNT = nR & gnt_any & gnt_sel;
    end else begin
      BUSY   = 1'b1;
      mWR    = we_q;
      mA     = addr_q + AW'(beat_q);
      r0DACK = we_q & ~owner_q;
      r1DACK = we_q & owner_q;
    end
    r0QV = rd_pend_q & ~rd_own_q;
    r1QV = rd_pend_q & rd_own_q;
    Q    = rd_pend_q ? mQ : '0;
  end

endmodule

// File: tb/tb_ram_burst_arbiter.sv
// Bench for ram_burst_arbiter: directed scenarios plus randomized bursts checked
// against a shadow memory and a transaction-level round-robin model.
module tb_ram_burst_arbiter;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 6;
  localparam int unsigned DEPTH = 64;

  logic C = 1'b0;
  logic nR = 1'b0;
  logic r0REQ = 0, r1REQ = 0, r0WE = 0, r1WE = 0;
  logic [AW-1:0] r0A = '0, r1A = '0;
  logic [3:0] r0LEN = '0, r1LEN = '0;
  logic [DW-1:0] r0D = '0, r1D = '0;
  logic r0GNT, r1GNT, r0DACK, r1DACK, r0QV, r1QV, BUSY, mWR;
  logic [DW-1:0] Q, mD, mQ;
  logic [AW-1:0] mA;

  ram_burst_arbiter #(.DW(DW), .AW(AW)) dut (
    .C(C), .nR(nR), .r0REQ(r0REQ), .r1REQ(r1REQ), .r0WE(r0WE), .r1WE(r1WE),
    .r0A(r0A), .r1A(r1A), .r0LEN(r0LEN), .r1LEN(r1LEN), .r0D(r0D), .r1D(r1D),
    .r0GNT(r0GNT), .r1GNT(r1GNT), .r0DACK(r0DACK), .r1DACK(r1DACK),
    .r0QV(r0QV), .r1QV(r1QV), .Q(Q), .BUSY(BUSY), .mWR(mWR), .mA(mA), .mD(mD),
    .mQ(mQ)
  );

  always #5 C = ~C;

  // Single-clock RAM, registered read, write-first.
  logic [DW-1:0] mem [DEPTH];
  logic mem_clr = 1'b1;
  always @(posedge C) begin
    if (mem_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (mWR) begin
      mem[mA] <= mD;
    end
    mQ <= mWR ? mD : mem[mA];
  end

  logic [7:0] ctl;
  assign ctl = {r0GNT, r1GNT, r0DACK, r1DACK, r0QV, r1QV, BUSY, mWR};

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] shadow [DEPTH];
  bit tb_last;

  function automatic logic [7:0] pk(input bit g0, g1, d0, d1, v0, v1, b, w);
    return {g0, g1, d0, d1, v0, v1, b, w};
  endfunction

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic drive(input int n, input bit req, input bit we, input logic [AW-1:0] a,
                       input logic [3:0] len);
    if (n == 0) begin
      r0REQ = req; r0WE = we; r0A = a; r0LEN = len;
    end else begin
      r1REQ = req; r1WE = we; r1A = a; r1LEN = len;
    end
  endtask

  task automatic apply_reset();
    nR = 1'b0; r0REQ = 0; r1REQ = 0;
    @(negedge C);
    tick();
    nR = 1'b1;
    tb_last = 1'b1;
  endtask

  task automatic test_reset();
    r0REQ = 1; r1REQ = 1;
    @(negedge C);
    vectors++; if (ctl !== 8'h00) begin miscompares++;
      $display("FAIL rst_ctl got %b want %b", ctl, 8'h00); end
    vectors++; if (mA !== '0 || Q !== '0) begin miscompares++;
      $display("FAIL rst_ma_q got mA=%h Q=%h want 0 0", mA, Q); end
    r0REQ = 0; r1REQ = 0;
    tick();
    nR = 1'b1; tb_last = 1'b1;
    @(negedge C);
    vectors++; if (ctl !== 8'h00) begin miscompares++;
      $display("FAIL rst_idle got %b want %b", ctl, 8'h00); end
    tick();
  endtask

  task automatic test_write_wrap();
    logic [AW-1:0] ea;
    drive(0, 1, 1, 6'h3E, 4'd3); r0D = 8'hA0;
    @(negedge C);
    vectors++; if (ctl !== pk(1,0,0,0,0,0,0,0)) begin miscompares++;
      $display("FAIL wr_gnt got %b want %b", ctl, pk(1,0,0,0,0,0,0,0)); end
    tb_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      r0D = DW'(8'hA0 + i);
      r0A = AW'($urandom); r0LEN = 4'($urandom); r0WE = 1'b0;  // must be ignored now
      ea = AW'(6'h3E + i);
      @(negedge C);
      vectors++; if (ctl !== pk(0,0,1,0,0,0,1,1) || mA !== ea || mD !== DW'(8'hA0 + i)) begin
        miscompares++;
        $display("FAIL wr_beat%0d got ctl=%b mA=%h mD=%h want %b %h %h", i, ctl, mA, mD,
                 pk(0,0,1,0,0,0,1,1), ea, DW'(8'hA0 + i)); end
      shadow[ea] = DW'(8'hA0 + i);
    end
    tick();
    r0REQ = 0;
    @(negedge C);
    vectors++; if (ctl !== 8'h00) begin miscompares++;
      $display("FAIL wr_end got %b want %b", ctl, 8'h00); end
    tick();
  endtask

  task automatic test_read_back();
    drive(0, 1, 0, 6'h3E, 4'd3);
    @(negedge C);
    vectors++; if (ctl !== pk(1,0,0,0,0,0,0,0)) begin miscompares++;
      $display("FAIL rd_gnt got %b want %b", ctl, pk(1,0,0,0,0,0,0,0)); end
    tb_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge C);
      vectors++; if (ctl !== pk(0,0,0,0,i>0,0,1,0) || mA !== AW'(6'h3E + i)) begin
        miscompares++;
        $display("FAIL rd_beat%0d got ctl=%b mA=%h want %b %h", i, ctl, mA,
                 pk(0,0,0,0,i>0,0,1,0), AW'(6'h3E + i)); end
      if (i > 0) begin
        vectors++; if (Q !== DW'(8'hA0 + i - 1)) begin miscompares++;
          $display("FAIL rd_q%0d got %h want %h", i - 1, Q, DW'(8'hA0 + i - 1)); end
      end
    end
    tick();
    r0REQ = 0;
    @(negedge C);
    vectors++; if (ctl !== pk(0,0,0,0,1,0,0,0) || Q !== 8'hA3) begin miscompares++;
      $display("FAIL rd_tail got ctl=%b Q=%h want %b a3", ctl, Q, pk(0,0,0,0,1,0,0,0)); end
    tick();
    @(negedge C);
    vectors++; if (ctl !== 8'h00) begin miscompares++;
      $display("FAIL rd_end got %b want %b", ctl, 8'h00); end
    tick();
  endtask

  // Last read QV coincides with a grant to the other requester.
  task automatic test_back_to_back();
    drive(0, 1, 0, 6'h3E, 4'd1);
    @(negedge C);
    tb_last = 1'b0;
    tick();
    @(negedge C);
    vectors++; if (ctl !== pk(0,0,0,0,0,0,1,0)) begin miscompares++;
      $display("FAIL b2b_beat0 got %b want %b", ctl, pk(0,0,0,0,0,0,1,0)); end
    tick();
    drive(1, 1, 1, 6'h05, 4'd0); r1D = 8'h5A;
    @(negedge C);
    vectors++; if (ctl !== pk(0,0,0,0,1,0,1,0) || Q !== 8'hA0) begin miscompares++;
      $display("FAIL b2b_beat1 got ctl=%b Q=%h want %b a0", ctl, Q, pk(0,0,0,0,1,0,1,0)); end
    tick();
    r0REQ = 0;
    @(negedge C);
    vectors++; if (ctl !== pk(0,1,0,0,1,0,0,0) || Q !== 8'hA1) begin miscompares++;
      $display("FAIL b2b_gnt_qv got ctl=%b Q=%h want %b a1", ctl, Q, pk(0,1,0,0,1,0,0,0)); end
    tb_last = 1'b1;
    tick();
    r1REQ = 0;
    @(negedge C);
    vectors++; if (ctl !== pk(0,0,0,1,0,0,1,1) || mA !== 6'h05 || mD !== 8'h5A) begin
      miscompares++;
      $display("FAIL b2b_wr got ctl=%b mA=%h mD=%h want %b 05 5a", ctl, mA, mD,
               pk(0,0,0,1,0,0,1,1)); end
    shadow[5] = 8'h5A;
    tick();
    @(negedge C);
    vectors++; if (ctl !== 8'h00) begin miscompares++;
      $display("FAIL b2b_end got %b want %b", ctl, 8'h00); end
    tick();
  endtask

  task automatic test_round_robin();
    bit w;
    apply_reset();
    drive(0, 1, 1, 6'h10, 4'd0); r0D = 8'h55;
    drive(1, 1, 1, 6'h20, 4'd0); r1D = 8'h66;
    for (int k = 0; k < 4; k++) begin
      w = !tb_last;
      @(negedge C);
      vectors++; if (ctl !== pk(!w,w,0,0,0,0,0,0)) begin miscompares++;
        $display("FAIL rr_gnt%0d got %b want %b", k, ctl, pk(!w,w,0,0,0,0,0,0)); end
      tb_last = w;
      tick();
      @(negedge C);
      vectors++; if (ctl !== pk(0,0,!w,w,0,0,1,1) || mA !== (w ? 6'h20 : 6'h10)) begin
        miscompares++;
        $display("FAIL rr_beat%0d got ctl=%b mA=%h want %b %h", k, ctl, mA,
                 pk(0,0,!w,w,0,0,1,1), (w ? 6'h20 : 6'h10)); end
      shadow[w ? 32 : 16] = w ? 8'h66 : 8'h55;
      tick();
    end
    r0REQ = 0; r1REQ = 0;
    @(negedge C);
    vectors++; if (ctl !== 8'h00) begin miscompares++;
      $display("FAIL rr_end got %b want %b", ctl, 8'h00); end
    tick();
  endtask

  task automatic test_abort();
    logic [AW-1:0] a;
    int qv_cnt;
    a = AW'($urandom); qv_cnt = 0;
    drive(0, 0, 0, '0, '0);
    drive(1, 1, 0, a, 4'd15);
    @(negedge C);
    vectors++; if (ctl !== pk(0,1,0,0,0,0,0,0)) begin miscompares++;
      $display("FAIL ab_gnt got %b want %b", ctl, pk(0,1,0,0,0,0,0,0)); end
    tb_last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) r1REQ = 0;
      @(negedge C);
      if (r1QV) qv_cnt++;
      vectors++; if (ctl !== pk(0,0,0,0,0,i>0,1,0) || mA !== AW'(a + AW'(i))) begin
        miscompares++;
        $display("FAIL ab_beat%0d got ctl=%b mA=%h want %b %h", i, ctl, mA,
                 pk(0,0,0,0,0,i>0,1,0), AW'(a + AW'(i))); end
      if (i > 0) begin
        vectors++; if (Q !== shadow[AW'(a + AW'(i - 1))]) begin miscompares++;
          $display("FAIL ab_q%0d got %h want %h", i - 1, Q, shadow[AW'(a + AW'(i - 1))]); end
      end
    end
    tick();
    @(negedge C);
    if (r1QV) qv_cnt++;
    vectors++; if (ctl !== pk(0,0,0,0,0,1,0,0) || Q !== shadow[AW'(a + 5)]) begin
      miscompares++;
      $display("FAIL ab_tail got ctl=%b Q=%h want %b %h", ctl, Q, pk(0,0,0,0,0,1,0,0),
               shadow[AW'(a + 5)]); end
    tick();
    @(negedge C);
    if (r1QV) qv_cnt++;
    vectors++; if (qv_cnt !== 6 || ctl !== 8'h00) begin miscompares++;
      $display("FAIL ab_count got qv=%0d ctl=%b want 6 %b", qv_cnt, ctl, 8'h00); end
    tick();
  endtask

  task automatic test_reset_midburst();
    logic [AW-1:0] a;
    a = AW'($urandom);
    drive(0, 1, 1, a, 4'd7);
    @(negedge C);
    tb_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      r0D = DW'($urandom);
      @(negedge C);
      vectors++; if (ctl !== pk(0,0,1,0,0,0,1,1)) begin miscompares++;
        $display("FAIL mr_beat%0d got %b want %b", i, ctl, pk(0,0,1,0,0,0,1,1)); end
      if (i < 2) shadow[AW'(a + AW'(i))] = r0D;
    end
    #1 nR = 1'b0;
    #1;
    vectors++; if (ctl !== 8'h00 || mA !== '0 || Q !== '0) begin miscompares++;
      $display("FAIL mr_wr_rst got ctl=%b mA=%h Q=%h want 0 0 0", ctl, mA, Q); end
    a = AW'($urandom);
    drive(0, 1, 1, a, 4'd7); r1REQ = 1;
    tick();
    nR = 1'b1; tb_last = 1'b1;
    @(negedge C);
    vectors++; if (ctl !== pk(1,0,0,0,0,0,0,0)) begin miscompares++;
      $display("FAIL mr_tie got %b want %b", ctl, pk(1,0,0,0,0,0,0,0)); end
    tb_last = 1'b0;
    tick();
    r0REQ = 0; r1REQ = 0; r0D = DW'($urandom);
    @(negedge C);
    vectors++; if (ctl !== pk(0,0,1,0,0,0,1,1) || mA !== a) begin miscompares++;
      $display("FAIL mr_first got ctl=%b mA=%h want %b %h", ctl, mA, pk(0,0,1,0,0,0,1,1), a); end
    shadow[a] = r0D;
    tick();
    // Pending read QV is discarded by reset.
    drive(0, 1, 0, AW'($urandom), 4'd7);
    @(negedge C);
    tb_last = 1'b0;
    tick();
    tick();
    @(negedge C);
    vectors++; if (ctl !== pk(0,0,0,0,1,0,1,0)) begin miscompares++;
      $display("FAIL mr_rd_beat1 got %b want %b", ctl, pk(0,0,0,0,1,0,1,0)); end
    #1 nR = 1'b0;
    #1;
    vectors++; if (ctl !== 8'h00 || Q !== '0) begin miscompares++;
      $display("FAIL mr_rd_rst got ctl=%b Q=%h want 0 0", ctl, Q); end
    r0REQ = 0;
    tick();
    nR = 1'b1; tb_last = 1'b1;
    @(negedge C);
    vectors++; if (ctl !== 8'h00) begin miscompares++;
      $display("FAIL mr_idle got %b want %b", ctl, 8'h00); end
    tick();
  endtask

  task automatic test_random();
    bit tie, we, w;
    logic [AW-1:0] a, ea;
    logic [3:0] len;
    int n, abort_at;
    logic [DW-1:0] d;
    apply_reset();
    for (int it = 0; it < 40; it++) begin
      tie = ($urandom_range(0, 3) == 0);
      we = 1'($urandom); a = AW'($urandom); len = 4'($urandom_range(0, 15));
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : 16;
      w = tie ? !tb_last : 1'($urandom);
      n = ((abort_at < int'(len)) ? abort_at : int'(len)) + 1;
      drive(!w, tie, 1'($urandom), AW'($urandom), 4'($urandom));
      drive(w, 1, we, a, len);
      @(negedge C);
      vectors++; if (ctl !== pk(!w,w,0,0,0,0,0,0)) begin miscompares++;
        $display("FAIL rnd%0d_gnt got %b want %b", it, ctl, pk(!w,w,0,0,0,0,0,0)); end
      tb_last = w;
      for (int i = 0; i < n; i++) begin
        tick();
        if (i == 0) begin
          if (w) r0REQ = 0; else r1REQ = 0;
        end
        if (i == abort_at) begin
          if (w) r1REQ = 0; else r0REQ = 0;
        end
        d = DW'($urandom);
        if (w) begin r1D = d; r0D = DW'($urandom); end
        else begin r0D = d; r1D = DW'($urandom); end
        ea = AW'(a + AW'(i));
        @(negedge C);
        vectors++;
        if (ctl !== pk(0,0,we&&!w,we&&w,!we&&i>0&&!w,!we&&i>0&&w,1,we) || mA !== ea ||
            (we && mD !== d) || (!we && i > 0 && Q !== shadow[AW'(ea - 1)])) begin
          miscompares++;
          $display("FAIL rnd%0d_beat%0d got ctl=%b mA=%h mD=%h Q=%h want %b %h %h %h", it, i,
                   ctl, mA, mD, Q, pk(0,0,we&&!w,we&&w,!we&&i>0&&!w,!we&&i>0&&w,1,we), ea, d,
                   shadow[AW'(ea - 1)]);
        end
        if (we) shadow[ea] = d;
      end
      tick();
      r0REQ = 0; r1REQ = 0;
      ea = AW'(a + AW'(n - 1));
      @(negedge C);
      vectors++;
      if (ctl !== pk(0,0,0,0,!we&&!w,!we&&w,0,0) || (!we && Q !== shadow[ea])) begin
        miscompares++;
        $display("FAIL rnd%0d_tail got ctl=%b Q=%h want %b %h", it, ctl, Q,
                 pk(0,0,0,0,!we&&!w,!we&&w,0,0), shadow[ea]);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) shadow[i] = '0;
    repeat (3) @(posedge C);
    #1 mem_clr = 1'b0;
    test_reset();
    test_write_wrap();
    test_read_back();
    test_back_to_back();
    test_round_robin();
    test_abort();
    test_reset_midburst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
